instr_fetch: RTL and testbench

- Instruction fetch/issue stage directly upstream of the controller.
- Reads 8-bit instruction words from a synchronous 16-entry instruction memory and latches each into an instruction register.
- Hands the controller a 4-bit opcode with a one-cycle op strobe, then waits a fixed execution window before fetching the next word.
- Owns the program counter, HALT detection and reserved-opcode skipping.

---
 rtl/instr_fetch_pkg.sv | 36 +++
 rtl/instr_fetch.sv | 91 +++++++++
 tb/tb_instr_fetch.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared ISA definitions for the fetch stage, controller and benches.
// Holds instruction field layout, opcode values and the fetch FSM state encodings.
package instr_fetch_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    localparam int OPC_HI = 7;
    localparam int OPC_LO = 4;
    localparam int OPD_HI = 3;
    localparam int OPD_LO = 0;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_ADD_A = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_SUB_A = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_AND_A = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_OR_A  = 4'h7;
    localparam logic [3:0] OP_SHR   = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_ISSUE  = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    // Opcodes 9..14 are reserved; HALT is handled separately.
    function automatic logic is_reserved(input logic [3:0] opc);
        return (opc >= 4'd9) && (opc != OP_HALT);
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch/issue: reads the instruction ROM, latches IR, strobes op to the controller.
// Latency: op 3 cycles after run is seen in IDLE; back-to-back ops every EXEC_CYCLES+3 cycles.
// Backpressure: none; run only gates new fetches, an instruction in flight always completes.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int               EXEC_CYCLES = 2,
    parameter logic [ADDR_W-1:0] START_ADDR = 4'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic [3:0]        opcode,
    output logic [3:0]        operand,
    output logic              op,
    output logic              halted,
    output logic              illegal
);

    localparam logic [3:0] EXEC_LD = 4'(EXEC_CYCLES);

    logic [2:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [3:0]        wait_cnt;
    logic [3:0]        ir_opc;
    logic [3:0]        ir_opd;
    logic [3:0]        mem_opc;

    assign mem_opc   = imem_data[OPC_HI:OPC_LO];
    assign imem_addr = pc;
    assign opcode    = ir_opc;
    assign operand   = ir_opd;
    assign op        = (state == ST_ISSUE);
    assign halted    = (state == ST_HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            pc       <= START_ADDR;
            wait_cnt <= 4'd0;
            ir_opc   <= 4'd0;
            ir_opd   <= 4'd0;
            illegal  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    ir_opc <= mem_opc;
                    ir_opd <= imem_data[OPD_HI:OPD_LO];
                    if (mem_opc == OP_HALT) begin
                        state <= ST_HALT;
                    end else if (is_reserved(mem_opc)) begin
                        // Skip the reserved word silently; only the sticky flag records it.
                        illegal <= 1'b1;
                        pc      <= pc + ADDR_W'(1);
                        state   <= ST_FETCH;
                    end else begin
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    pc       <= pc + ADDR_W'(1);
                    wait_cnt <= EXEC_LD;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= run ? ST_FETCH : ST_IDLE;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a program-walking model predicts every op pulse and the halt cycle.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int EXEC = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic       run_w = 1'b0;
    logic [3:0] imem_addr, opcode, operand;
    logic [3:0] imem_addr_w, opcode_w, operand_w;
    logic [7:0] imem_data = 8'h00;
    logic [7:0] imem_data_w = 8'h00;
    logic       op, halted, illegal;
    logic       op_w, halted_w, illegal_w;

    logic [7:0] rom [16];
    logic [7:0] rom_w [16];

    typedef struct {
        int addr;
        int opc;
        int opd;
        int ill;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t qw[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_halt_cyc = -1;
    int   nxt = 0;
    bit   pend = 1'b0;
    bit   hprev = 1'b0;

    instr_fetch #(.EXEC_CYCLES(EXEC), .START_ADDR(4'h0)) dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .opcode(opcode), .operand(operand), .op(op),
        .halted(halted), .illegal(illegal)
    );

    instr_fetch #(.EXEC_CYCLES(1), .START_ADDR(4'hE)) dut_w (
        .clk(clk), .reset(reset), .run(run_w),
        .imem_addr(imem_addr_w), .imem_data(imem_data_w),
        .opcode(opcode_w), .operand(operand_w), .op(op_w),
        .halted(halted_w), .illegal(illegal_w)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        imem_data   <= rom[imem_addr];
        imem_data_w <= rom_w[imem_addr_w];
    end

    function automatic void chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Monitor: pops the scoreboards whenever either DUT strobes op.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (reset) begin
            pend  = 1'b0;
            hprev = 1'b0;
        end else begin
            if (pend) begin
                chk("pc_incr", int'(imem_addr), nxt);
                pend = 1'b0;
            end
            if (op) begin
                if (q.size() == 0) begin
                    chk("unexpected_op", int'(op), 0);
                end else begin
                    e = q.pop_front();
                    chk("op_cycle", cyc, e.cyc);
                    chk("opcode", int'(opcode), e.opc);
                    chk("operand", int'(operand), e.opd);
                    chk("op_addr", int'(imem_addr), e.addr);
                    chk("illegal_at_op", int'(illegal), e.ill);
                    nxt  = (e.addr + 1) % 16;
                    pend = 1'b1;
                end
            end
            if (halted && !hprev) begin
                chk("halt_cycle", cyc, exp_halt_cyc);
            end
            hprev = halted;
            if (op_w) begin
                if (qw.size() == 0) begin
                    chk("unexpected_op_w", int'(op_w), 0);
                end else begin
                    e = qw.pop_front();
                    chk("w_op_cycle", cyc, e.cyc);
                    chk("w_op_addr", int'(imem_addr_w), e.addr);
                    chk("w_opcode", int'(opcode_w), e.opc);
                    chk("w_operand", int'(operand_w), e.opd);
                end
            end
        end
    end

    // Walks the program word by word: each executable word yields one op, spaced EXEC+3 apart;
    // a reserved word costs a fetch+decode (2 cycles) and sets the sticky flag.
    function automatic void model(input int pc0, input int k, output int hpc, output int ill);
        int         pc;
        int         t;
        logic [7:0] w;
        pc  = pc0;
        t   = k + 4;
        ill = 0;
        hpc = -1;
        for (int n = 0; n < 64 && hpc < 0; n++) begin
            w = rom[pc];
            if (w[7:4] == 4'hF) begin
                hpc          = pc;
                exp_halt_cyc = t;
            end else if (w[7:4] >= 4'd9) begin
                ill = 1;
                pc  = (pc + 1) % 16;
                t   = t + 2;
            end else begin
                q.push_back('{pc, int'(w[7:4]), int'(w[3:0]), ill, t});
                pc = (pc + 1) % 16;
                t  = t + EXEC + 3;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        run   = 1'b0;
        run_w = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_imem_addr", int'(imem_addr), 0);
        chk("rst_opcode", int'(opcode), 0);
        chk("rst_operand", int'(operand), 0);
        chk("rst_op", int'(op), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_illegal", int'(illegal), 0);
        q.delete();
        qw.delete();
        exp_halt_cyc = -1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    endtask

    task automatic run_and_halt(input int hpc, input int ill, input int budget);
        int w;
        w = 0;
        while (!halted && w < budget) begin
            step();
            w++;
        end
        chk("halted", int'(halted), 1);
        chk("halt_addr", int'(imem_addr), hpc);
        chk("illegal_sticky", int'(illegal), ill);
        repeat (20) step();
        chk("halt_hold_addr", int'(imem_addr), hpc);
        chk("halt_hold", int'(halted), 1);
        chk("ops_outstanding", q.size(), 0);
    endtask

    task automatic prog();
        int hpc, ill, k;
        k = cyc;
        model(0, k, hpc, ill);
        run = 1'b1;
        run_and_halt(hpc, ill, 200);
    endtask

    task automatic wait_ops_done();
        int w;
        w = 0;
        while (q.size() != 0 && w < 30) begin
            step();
            w++;
        end
        chk("first_op_seen", q.size(), 0);
    endtask

    initial begin
        int hpc, ill, k;
        logic [3:0] opc;
        int h;

        for (int i = 0; i < 16; i++) rom_w[i] = 8'h00;
        rom_w[14] = 8'h01;
        rom_w[15] = 8'h02;
        rom_w[0]  = 8'h03;
        rom_w[1]  = 8'hF0;
        clear_rom();
        #3;

        // Reset, then idle with run low.
        do_reset();
        repeat (10) begin
            step();
            chk("idle_addr", int'(imem_addr), 0);
            chk("idle_halted", int'(halted), 0);
        end

        clear_rom(); rom[0] = 8'h13; rom[1] = 8'hF0;
        do_reset(); prog();

        clear_rom(); rom[0] = 8'h05; rom[1] = 8'h27; rom[2] = 8'h80; rom[3] = 8'hF0;
        do_reset(); prog();

        clear_rom(); rom[0] = 8'h9A; rom[1] = 8'h4F; rom[2] = 8'hF0;
        do_reset(); prog();

        clear_rom(); rom[0] = 8'h61; rom[1] = 8'hF0;
        do_reset(); prog();

        // Drop run during WAIT: park in IDLE at PC 1, then resume.
        clear_rom(); rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'hF0;
        do_reset();
        k = cyc;
        q.push_back('{0, 1, 1, 0, k + 4});
        run = 1'b1;
        wait_ops_done();
        run = 1'b0;
        repeat (12) step();
        chk("park_addr", int'(imem_addr), 1);
        chk("park_halted", int'(halted), 0);
        k = cyc;
        model(1, k, hpc, ill);
        run = 1'b1;
        run_and_halt(hpc, ill, 100);

        // Reset asserted mid-WAIT; do_reset checks outputs before the next edge.
        do_reset();
        k = cyc;
        q.push_back('{0, 1, 1, 0, k + 4});
        run = 1'b1;
        wait_ops_done();
        chk("mid_wait_addr", int'(imem_addr), 1);
        do_reset();

        // PC wrap on the START_ADDR=14, EXEC_CYCLES=1 instance.
        k = cyc;
        qw.push_back('{14, 0, 1, 0, k + 4});
        qw.push_back('{15, 0, 2, 0, k + 8});
        qw.push_back('{0, 0, 3, 0, k + 12});
        run_w = 1'b1;
        for (int w = 0; w < 40 && !halted_w; w++) step();
        chk("w_halted", int'(halted_w), 1);
        chk("w_halt_addr", int'(imem_addr_w), 1);
        chk("w_illegal", int'(illegal_w), 0);
        chk("w_ops_outstanding", qw.size(), 0);
        run_w = 1'b0;

        // Random programs with a HALT placed somewhere in the ROM.
        for (int it = 0; it < 8; it++) begin
            h = $urandom_range(0, 15);
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 3) == 0) opc = 4'($urandom_range(9, 14));
                else                           opc = 4'($urandom_range(0, 8));
                rom[i] = (i == h) ? 8'hF0 : {opc, 4'($urandom_range(0, 15))};
            end
            do_reset();
            prog();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
